iq_dual: RTL and testbench

IQ_DUAL -- requirements
Module: iq_dual

---
 rtl/iq_dual.sv | 108 ++++++++++
 tb/tb_iq_dual.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/iq_dual.sv
// Dual-output show-ahead instruction queue: circular buffer with 1 enqueue and 0-2 dequeues per cycle.
// Optional empty-queue bypass of the incoming instruction is enabled by defining IQ_BYPASS_EN.
module iq_dual #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned INST_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned AFULL_TH = DEPTH - 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rdy,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic [INST_W-1:0]       in_inst,
    input  logic [ADDR_W-1:0]       in_pc,
    output logic                    full,
    output logic                    afull,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    out0_valid,
    output logic [INST_W-1:0]       out0_inst,
    output logic [ADDR_W-1:0]       out0_pc,
    output logic                    out1_valid,
    output logic [INST_W-1:0]       out1_inst,
    output logic [ADDR_W-1:0]       out1_pc,
    input  logic [1:0]              deq_cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, head_p1;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

    logic       accept, byp, byp_used, wr_en;
    logic [1:0] n_storage, n_valid, deq_eff, deq_mem;

    always_comb begin
        accept    = rdy && !clr;
        head_p1   = head_q + PTR_W'(1);
        full      = (count_q == CNT_W'(DEPTH));
        afull     = (count_q >= CNT_W'(AFULL_TH));
        count     = count_q;
        n_storage = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];
`ifdef IQ_BYPASS_EN
        byp       = accept && in_valid && (count_q < CNT_W'(2));
`else
        byp       = 1'b0;
`endif
        n_valid   = n_storage + {1'b0, byp};
        deq_eff   = (deq_cnt > n_valid) ? n_valid : deq_cnt;
        // A bypassed entry consumed in the same cycle never touches storage
        byp_used  = byp && (deq_eff > n_storage);
        deq_mem   = deq_eff - {1'b0, byp_used};
        wr_en     = accept && in_valid && !full && !byp_used;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (rdy) begin
            head_d  = head_q + PTR_W'(deq_mem);
            tail_d  = tail_q + PTR_W'(wr_en);
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(deq_mem);
        end

        out0_valid = (count_q != '0);
        out0_inst  = inst_mem_q[head_q];
        out0_pc    = pc_mem_q[head_q];
        out1_valid = (count_q >= CNT_W'(2));
        out1_inst  = inst_mem_q[head_p1];
        out1_pc    = pc_mem_q[head_p1];
`ifdef IQ_BYPASS_EN
        if (byp && count_q == '0) begin
            out0_valid = 1'b1;
            out0_inst  = in_inst;
            out0_pc    = in_pc;
        end
        if (byp && count_q == CNT_W'(1)) begin
            out1_valid = 1'b1;
            out1_inst  = in_inst;
            out1_pc    = in_pc;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            inst_mem_q[tail_q] <= in_inst;
            pc_mem_q[tail_q]   <= in_pc;
        end
    end
endmodule

// File: tb/tb_iq_dual.sv
// Directed bench for iq_dual: a queue scoreboard predicts outputs and occupancy every cycle.
// Handles both builds (IQ_BYPASS_EN defined or not).
module tb_iq_dual;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rdy, clr, in_valid;
    logic [31:0] in_inst, in_pc;
    logic        full, afull;
    logic [4:0]  count;
    logic        out0_valid, out1_valid;
    logic [31:0] out0_inst, out0_pc, out1_inst, out1_pc;
    logic [1:0]  deq_cnt;

    int   n_pass = 0;
    int   n_total = 0;
    ent_t q[$];

    iq_dual #(.DEPTH(16), .INST_W(32), .ADDR_W(32), .AFULL_TH(14)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clr(clr),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
        .full(full), .afull(afull), .count(count),
        .out0_valid(out0_valid), .out0_inst(out0_inst), .out0_pc(out0_pc),
        .out1_valid(out1_valid), .out1_inst(out1_inst), .out1_pc(out1_pc),
        .deq_cnt(deq_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drives one cycle, checks outputs against the scoreboard, then advances the model past the edge.
    task automatic cycle(input logic r, input logic c, input logic v, input logic [31:0] pc,
                         input logic [1:0] dq, output logic acc);
        ent_t        e;
        ent_t        view[$];
        int unsigned sz, avail, de;
        logic        byp;
        e.pc  = pc;
        e.inst = pc ^ 32'hC0DE_0000;
        rdy = r; clr = c; in_valid = v; in_pc = pc; in_inst = e.inst; deq_cnt = dq;
        #1;
        sz   = q.size();
        view = q;
        byp  = 1'b0;
`ifdef IQ_BYPASS_EN
        if (r && !c && v && sz < 2) begin
            byp = 1'b1;
            view.push_back(e);
        end
`endif
        chk("count", 64'(count), 64'(sz));
        chk("full", 64'(full), 64'(sz == 16));
        chk("afull", 64'(afull), 64'(sz >= 14));
        chk("out0_valid", 64'(out0_valid), 64'(view.size() >= 1));
        chk("out1_valid", 64'(out1_valid), 64'(view.size() >= 2));
        if (view.size() >= 1) begin
            chk("out0_pc", 64'(out0_pc), 64'(view[0].pc));
            chk("out0_inst", 64'(out0_inst), 64'(view[0].inst));
        end
        if (view.size() >= 2) begin
            chk("out1_pc", 64'(out1_pc), 64'(view[1].pc));
            chk("out1_inst", 64'(out1_inst), 64'(view[1].inst));
        end
        acc = 1'b0;
        if (c) begin
            q.delete();
        end else if (r) begin
            avail = (view.size() >= 2) ? 2 : view.size();
            de    = (int'(dq) > int'(avail)) ? avail : int'(dq);
            if (byp && de > sz) begin
                q.delete();
                acc = 1'b1;
            end else begin
                repeat (de) void'(q.pop_front());
                if (v && sz < 16) begin
                    q.push_back(e);
                    acc = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] next_pc;
        logic        acc;
        ent_t        e;
        rdy = 1'b0; clr = 1'b0; in_valid = 1'b0; deq_cnt = 2'd0;
        in_pc = '0; in_inst = '0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out0_valid", 64'(out0_valid), 64'd0);
        chk("rst_out1_valid", 64'(out1_valid), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_afull", 64'(afull), 64'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        next_pc = 32'h0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 1'b1, next_pc, 2'd0, acc);
            if (acc) next_pc += 32'd4;
        end
        chk("five_count", 64'(count), 64'd5);
        chk("five_out0_pc", 64'(out0_pc), 64'h0);
        chk("five_out1_pc", 64'(out1_pc), 64'h4);
        chk("five_out0_valid", 64'(out0_valid), 64'd1);
        chk("five_out1_valid", 64'(out1_valid), 64'd1);

        cycle(1'b1, 1'b1, 1'b0, 32'h0, 2'd0, acc);
        next_pc = 32'h0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 1'b1, next_pc, 2'd0, acc);
            if (acc) next_pc += 32'd4;
        end
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_afull", 64'(afull), 64'd1);
        cycle(1'b1, 1'b0, 1'b1, next_pc, 2'd0, acc);
        if (acc) next_pc += 32'd4;
        chk("held_count", 64'(count), 64'd16);
        cycle(1'b1, 1'b0, 1'b1, next_pc, 2'd2, acc);
        if (acc) next_pc += 32'd4;
        chk("drain_count", 64'(count), 64'd14);
        chk("drain_full", 64'(full), 64'd0);
        cycle(1'b1, 1'b0, 1'b1, next_pc, 2'd0, acc);
        if (acc) next_pc += 32'd4;
        chk("accept17_count", 64'(count), 64'd15);

        cycle(1'b1, 1'b0, 1'b1, next_pc, 2'd0, acc);
        if (acc) next_pc += 32'd4;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, 1'b1, next_pc, 2'd2, acc);
            if (acc) next_pc += 32'd4;
        end

        cycle(1'b1, 1'b1, 1'b0, 32'h0, 2'd0, acc);
        cycle(1'b1, 1'b0, 1'b1, 32'h200, 2'd0, acc);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 2'd2, acc);
        chk("clamp1_count", 64'(count), 64'd0);
        chk("clamp1_valid", 64'(out0_valid), 64'd0);
        cycle(1'b1, 1'b0, 1'b1, 32'h204, 2'd0, acc);
        cycle(1'b1, 1'b0, 1'b1, 32'h208, 2'd0, acc);
        chk("clamp1_head", 64'(out0_pc), 64'h204);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 2'd3, acc);
        chk("clamp3_count", 64'(count), 64'd0);
        cycle(1'b1, 1'b0, 1'b1, 32'h20C, 2'd0, acc);
        chk("clamp3_head", 64'(out0_pc), 64'h20C);

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'h300 + 32'(4 * i), 2'd0, acc);
        cycle(1'b0, 1'b0, 1'b1, 32'h400, 2'd2, acc);
        chk("hold_count", 64'(count), 64'd4);
        chk("hold_out0_pc", 64'(out0_pc), 64'h20C);
        cycle(1'b0, 1'b1, 1'b1, 32'h404, 2'd2, acc);
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_out0_valid", 64'(out0_valid), 64'd0);
        chk("clr_out1_valid", 64'(out1_valid), 64'd0);

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'h500 + 32'(4 * i), 2'd0, acc);
        rdy = 1'b1; clr = 1'b0; in_valid = 1'b0; deq_cnt = 2'd0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out0_valid", 64'(out0_valid), 64'd0);
        chk("arst_out1_valid", 64'(out1_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        q.delete();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, acc);

        e.pc = 32'h100;
        e.inst = 32'h100 ^ 32'hC0DE_0000;
        rdy = 1'b1; clr = 1'b0; in_valid = 1'b1; in_pc = e.pc; in_inst = e.inst; deq_cnt = 2'd1;
        #1;
`ifdef IQ_BYPASS_EN
        chk("byp_out0_valid", 64'(out0_valid), 64'd1);
        chk("byp_out0_pc", 64'(out0_pc), 64'h100);
`else
        chk("nobyp_out0_valid", 64'(out0_valid), 64'd0);
        q.push_back(e);
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0; deq_cnt = 2'd0;
        #1;
`ifdef IQ_BYPASS_EN
        chk("byp_next_count", 64'(count), 64'd0);
        chk("byp_next_valid", 64'(out0_valid), 64'd0);
`else
        chk("nobyp_next_valid", 64'(out0_valid), 64'd1);
        chk("nobyp_next_pc", 64'(out0_pc), 64'h100);
        chk("nobyp_next_count", 64'(count), 64'd1);
`endif
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, acc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
